// File: rtl/pkt_rx_reader.sv
// Pulls packets from a MAC receive port into a small output FIFO with framing repair.
// Define PKT_RX_READER_STATS_EN to build the packet/byte/error statistics counters.
module pkt_rx_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WORDS  = 1200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_rx_avail,
  input  logic        pkt_rx_val,
  input  logic        pkt_rx_sop,
  input  logic        pkt_rx_eop,
  input  logic        pkt_rx_err,
  input  logic [2:0]  pkt_rx_mod,
  input  logic [63:0] pkt_rx_data,
  output logic        pkt_rx_ren,
  output logic [63:0] out_data,
  output logic [2:0]  out_mod,
  output logic        out_val,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  input  logic        out_rdy,
  output logic [31:0] pkt_cnt,
  output logic [31:0] byte_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] proto_err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, READ, DISCARD} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  mod;
    logic        sop;
    logic        eop;
    logic        err;
  } entry_t;

  state_t        state, state_nxt;
  entry_t        mem [FIFO_DEPTH];
  entry_t        wr_entry, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          ren_q, in_pkt, any_err, any_err_this;
  logic          room, wr_en, pop, collide, trunc;
  logic [WW-1:0] word_cnt, words_this;

  // A read issued last cycle returns data this cycle, so it already claims a slot.
  assign used = {1'b0, count} + {{CW{1'b0}}, ren_q};
  assign room = used <= (CW+1)'(FIFO_DEPTH - 2);

  assign out_val  = (count != '0);
  assign pop      = out_val && out_rdy;
  assign head     = out_val ? mem[rd_ptr] : '0;
  assign out_data = head.data;
  assign out_mod  = head.mod;
  assign out_sop  = head.sop;
  assign out_eop  = head.eop;
  assign out_err  = head.err;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    wr_en    = 1'b0;
    collide  = 1'b0;
    wr_entry = '{data: pkt_rx_data, mod: pkt_rx_mod, sop: pkt_rx_sop,
                 eop: pkt_rx_eop, err: pkt_rx_err};
    if (pkt_rx_val && state != DISCARD) begin
      if (pkt_rx_sop) begin
        wr_en   = 1'b1;
        collide = in_pkt;
      end else if (in_pkt) begin
        wr_en = 1'b1;
      end
    end
    words_this   = pkt_rx_sop ? WW'(1) : word_cnt + WW'(1);
    any_err_this = (pkt_rx_sop ? 1'b0 : any_err) | pkt_rx_err;
    trunc        = wr_en && !pkt_rx_eop && (words_this == WW'(MAX_WORDS));
    // A sop inside a packet closes the unfinished one by flagging the new sop word.
    if (collide) wr_entry.err = 1'b1;
    if (trunc) begin
      wr_entry.eop = 1'b1;
      wr_entry.err = 1'b1;
      wr_entry.mod = 3'd0;
    end
  end

  always_comb begin
    state_nxt  = state;
    pkt_rx_ren = 1'b0;
    case (state)
      IDLE: if (pkt_rx_avail && room) state_nxt = READ;
      READ: begin
        pkt_rx_ren = !(pkt_rx_val && pkt_rx_eop) && room;
        if (trunc)                         state_nxt = DISCARD;
        else if (pkt_rx_val && pkt_rx_eop) state_nxt = IDLE;
      end
      DISCARD: begin
        pkt_rx_ren = !(pkt_rx_val && pkt_rx_eop);
        if (pkt_rx_val && pkt_rx_eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) pkt_rx_ren = 1'b0;
  end

  // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ren_q    <= 1'b0;
      in_pkt   <= 1'b0;
      word_cnt <= '0;
      any_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      ren_q <= pkt_rx_ren;
      if (wr_en) begin
        wr_ptr   <= wr_ptr + AW'(1);
        in_pkt   <= !wr_entry.eop;
        word_cnt <= words_this;
        any_err  <= any_err_this;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the head is masked by out_val so stale entries never show.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

`ifdef PKT_RX_READER_STATS_EN
  logic        orphan, last;
  logic [31:0] pkt_bytes;
  logic [31:0] pkt_cnt_q, byte_cnt_q;
  logic [15:0] err_cnt_q, proto_cnt_q;

  assign orphan    = pkt_rx_val && state != DISCARD && !pkt_rx_sop && !in_pkt;
  assign last      = wr_en && wr_entry.eop;
  assign pkt_bytes = ((32'(words_this) - 32'd1) << 3) +
                     ((wr_entry.mod == 3'd0) ? 32'd8 : 32'(wr_entry.mod));

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      err_cnt_q   <= '0;
      proto_cnt_q <= '0;
    end else begin
      if (last) begin
        pkt_cnt_q  <= pkt_cnt_q + 32'd1;
        byte_cnt_q <= byte_cnt_q + pkt_bytes;
        if (any_err_this || trunc) err_cnt_q <= err_cnt_q + 16'd1;
      end
      if (orphan || collide) proto_cnt_q <= proto_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt       = pkt_cnt_q;
  assign byte_cnt      = byte_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign proto_err_cnt = proto_cnt_q;
`else
  assign pkt_cnt       = '0;
  assign byte_cnt      = '0;
  assign err_cnt       = '0;
  assign proto_err_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_rx_reader.sv
// Directed bench for pkt_rx_reader: a MAC model answers pkt_rx_ren, a monitor logs out_*.
// Instance a uses default parameters, instance b uses MAX_WORDS=4 for truncation.
module tb_pkt_rx_reader;
  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  mod;
    logic        sop;
    logic        eop;
    logic        err;
  } word_t;

`ifdef PKT_RX_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, sel, out_rdy;
  logic mac_avail, mac_val, mac_sop, mac_eop, mac_err;
  logic [2:0]  mac_mod;
  logic [63:0] mac_data;

  logic        a_ren, a_val, a_sop, a_eop, a_err, b_ren, b_val, b_sop, b_eop, b_err;
  logic [2:0]  a_mod, b_mod;
  logic [63:0] a_data, b_data;
  logic [31:0] a_pkt, a_byte, b_pkt, b_byte;
  logic [15:0] a_errc, a_proto, b_errc, b_proto;

  logic        o_ren, o_val, o_sop, o_eop, o_err;
  logic [2:0]  o_mod;
  logic [63:0] o_data;
  logic [31:0] o_pkt, o_byte;
  logic [15:0] o_errc, o_proto;

  int checks = 0, errors = 0, cyc = 0, overreads = 0;
  word_t mac_q[$], inj_q[$], rx_q[$];
  int    tx_cyc[$], rx_cyc[$];

  pkt_rx_reader dut_a (
    .clk(clk), .rst(rst),
    .pkt_rx_avail(mac_avail & ~sel), .pkt_rx_val(mac_val & ~sel),
    .pkt_rx_sop(mac_sop), .pkt_rx_eop(mac_eop), .pkt_rx_err(mac_err),
    .pkt_rx_mod(mac_mod), .pkt_rx_data(mac_data), .pkt_rx_ren(a_ren),
    .out_data(a_data), .out_mod(a_mod), .out_val(a_val), .out_sop(a_sop),
    .out_eop(a_eop), .out_err(a_err), .out_rdy(out_rdy),
    .pkt_cnt(a_pkt), .byte_cnt(a_byte), .err_cnt(a_errc), .proto_err_cnt(a_proto)
  );

  pkt_rx_reader #(.FIFO_DEPTH(4), .MAX_WORDS(4)) dut_b (
    .clk(clk), .rst(rst),
    .pkt_rx_avail(mac_avail & sel), .pkt_rx_val(mac_val & sel),
    .pkt_rx_sop(mac_sop), .pkt_rx_eop(mac_eop), .pkt_rx_err(mac_err),
    .pkt_rx_mod(mac_mod), .pkt_rx_data(mac_data), .pkt_rx_ren(b_ren),
    .out_data(b_data), .out_mod(b_mod), .out_val(b_val), .out_sop(b_sop),
    .out_eop(b_eop), .out_err(b_err), .out_rdy(out_rdy),
    .pkt_cnt(b_pkt), .byte_cnt(b_byte), .err_cnt(b_errc), .proto_err_cnt(b_proto)
  );

  assign o_ren   = sel ? b_ren   : a_ren;
  assign o_val   = sel ? b_val   : a_val;
  assign o_sop   = sel ? b_sop   : a_sop;
  assign o_eop   = sel ? b_eop   : a_eop;
  assign o_err   = sel ? b_err   : a_err;
  assign o_mod   = sel ? b_mod   : a_mod;
  assign o_data  = sel ? b_data  : a_data;
  assign o_pkt   = sel ? b_pkt   : a_pkt;
  assign o_byte  = sel ? b_byte  : a_byte;
  assign o_errc  = sel ? b_errc  : a_errc;
  assign o_proto = sel ? b_proto : a_proto;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // MAC model: a read sampled in one cycle returns the next queued word in the following one.
  initial begin
    logic  ren_s;
    word_t w;
    mac_val = 1'b0; mac_sop = 1'b0; mac_eop = 1'b0; mac_err = 1'b0;
    mac_mod = '0;   mac_data = '0;  mac_avail = 1'b0;
    forever begin
      @(negedge clk);
      ren_s = o_ren;
      @(posedge clk);
      #1;
      mac_val = 1'b0;
      if (ren_s) begin
        if (mac_q.size() != 0) begin
          w = mac_q.pop_front();
          {mac_data, mac_mod, mac_sop, mac_eop, mac_err} = w;
          mac_val = 1'b1;
          tx_cyc.push_back(cyc);
        end else begin
          overreads++;
        end
      end else if (inj_q.size() != 0) begin
        w = inj_q.pop_front();
        {mac_data, mac_mod, mac_sop, mac_eop, mac_err} = w;
        mac_val = 1'b1;
      end
      mac_avail = (mac_q.size() != 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (o_val && out_rdy) begin
      rx_q.push_back({o_data, o_mod, o_sop, o_eop, o_err});
      rx_cyc.push_back(cyc);
    end
  end

  function automatic word_t mkw(input logic [63:0] d, input logic s, input logic e,
                                input logic er, input logic [2:0] m);
    return '{data: d, mod: m, sop: s, eop: e, err: er};
  endfunction

  function automatic logic [71:0] st(input logic [71:0] v);
    return STATS ? v : '0;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag, input int p, input int b, input int e,
                             input int pr);
    check({tag, "_pkt_cnt"}, o_pkt, st(p));
    check({tag, "_byte_cnt"}, o_byte, st(b));
    check({tag, "_err_cnt"}, o_errc, st(e));
    check({tag, "_proto_err_cnt"}, o_proto, st(pr));
  endtask

  task automatic check_rx(input string tag, input int i, input word_t exp);
    word_t got;
    got = (i < rx_q.size()) ? rx_q[i] : 'x;
    check($sformatf("%s_w%0d", tag, i), got, exp);
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    check(tag, rx_q.size(), n);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    rx_q.delete(); rx_cyc.delete(); tx_cyc.delete();
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ren", o_ren, 0);
    check("rst_out_val", o_val, 0);
    check("rst_out_data", o_data, 0);
    check("rst_out_flags", {o_sop, o_eop, o_err, o_mod}, 0);
    check_stats("rst", 0, 0, 0, 0);
    tick();
    rst = 1'b0;

    // 3-word packet, mod 5: 1-cycle latency, 21 bytes
    clear_logs();
    mac_q.push_back(mkw(64'hA000_0000_0000_0000, 1, 0, 0, 0));
    mac_q.push_back(mkw(64'hA000_0000_0000_0001, 0, 0, 0, 0));
    mac_q.push_back(mkw(64'hA000_0000_0000_0002, 0, 1, 0, 5));
    wait_rx("t1_count", 3, 40);
    check_rx("t1", 0, mkw(64'hA000_0000_0000_0000, 1, 0, 0, 0));
    check_rx("t1", 1, mkw(64'hA000_0000_0000_0001, 0, 0, 0, 0));
    check_rx("t1", 2, mkw(64'hA000_0000_0000_0002, 0, 1, 0, 5));
    for (int i = 0; i < 3; i++) check($sformatf("t1_latency%0d", i), rx_cyc[i] - tx_cyc[i], 1);
    check_stats("t1", 1, 21, 0, 0);

    // 10-word packet against a stalled sink: reads stop with the FIFO at 3 words
    tick();
    out_rdy = 1'b0;
    clear_logs();
    for (int i = 0; i < 10; i++)
      mac_q.push_back(mkw(64'hB000_0000_0000_0000 + 64'(i), i == 0, i == 9, 0, 0));
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t2_words_read_in_stall", tx_cyc.size(), 3);
    check("t2_ren_in_stall", o_ren, 0);
    check("t2_head", {o_data, o_mod, o_sop, o_eop, o_err},
          mkw(64'hB000_0000_0000_0000, 1, 0, 0, 0));
    tick();
    out_rdy = 1'b1;
    wait_rx("t2_count", 10, 100);
    for (int i = 0; i < 10; i++)
      check_rx("t2", i, mkw(64'hB000_0000_0000_0000 + 64'(i), i == 0, i == 9, 0, 0));
    check_stats("t2", 2, 101, 0, 0);

    // two back-to-back packets, pkt_rx_err on word 1 of the first
    clear_logs();
    mac_q.push_back(mkw(64'hC000_0000_0000_0000, 1, 0, 0, 0));
    mac_q.push_back(mkw(64'hC000_0000_0000_0001, 0, 0, 1, 0));
    mac_q.push_back(mkw(64'hC000_0000_0000_0002, 0, 1, 0, 3));
    mac_q.push_back(mkw(64'hD000_0000_0000_0000, 1, 0, 0, 0));
    mac_q.push_back(mkw(64'hD000_0000_0000_0001, 0, 1, 0, 1));
    wait_rx("t3_count", 5, 60);
    check_rx("t3", 1, mkw(64'hC000_0000_0000_0001, 0, 0, 1, 0));
    check_rx("t3", 2, mkw(64'hC000_0000_0000_0002, 0, 1, 0, 3));
    check_rx("t3", 3, mkw(64'hD000_0000_0000_0000, 1, 0, 0, 0));
    check_rx("t3", 4, mkw(64'hD000_0000_0000_0001, 0, 1, 0, 1));
    check("t3_idle_gap", (tx_cyc[3] - tx_cyc[2]) >= 2, 1);
    check_stats("t3", 4, 129, 1, 0);

    // orphan word in IDLE, then a second sop inside a packet
    clear_logs();
    inj_q.push_back(mkw(64'hE000_0000_0000_0000, 0, 0, 0, 0));
    repeat (6) @(negedge clk);
    check("t4_orphan_dropped", rx_q.size(), 0);
    check("t4_orphan_proto", o_proto, st(1));
    mac_q.push_back(mkw(64'hF000_0000_0000_0000, 1, 0, 0, 0));
    mac_q.push_back(mkw(64'hF000_0000_0000_0001, 0, 0, 0, 0));
    mac_q.push_back(mkw(64'hF000_0000_0000_0002, 1, 0, 0, 0));
    mac_q.push_back(mkw(64'hF000_0000_0000_0003, 0, 0, 0, 0));
    mac_q.push_back(mkw(64'hF000_0000_0000_0004, 0, 1, 0, 2));
    wait_rx("t4_count", 5, 60);
    check_rx("t4", 0, mkw(64'hF000_0000_0000_0000, 1, 0, 0, 0));
    check_rx("t4", 2, mkw(64'hF000_0000_0000_0002, 1, 0, 1, 0));
    check_rx("t4", 4, mkw(64'hF000_0000_0000_0004, 0, 1, 0, 2));
    check_stats("t4", 5, 147, 1, 2);

    // MAX_WORDS=4 instance: 7-word packet is cut after word 3, rest discarded
    tick();
    sel = 1'b1;
    clear_logs();
    for (int i = 0; i < 7; i++)
      mac_q.push_back(mkw(64'h6000_0000_0000_0000 + 64'(i), i == 0, i == 6, 0, 4));
    for (int i = 0; i < 60 && tx_cyc.size() < 7; i++) @(negedge clk);
    check("t5_all_read", tx_cyc.size(), 7);
    wait_rx("t5_count", 4, 10);
    check_rx("t5", 0, mkw(64'h6000_0000_0000_0000, 1, 0, 0, 4));
    check_rx("t5", 2, mkw(64'h6000_0000_0000_0002, 0, 0, 0, 4));
    check_rx("t5", 3, mkw(64'h6000_0000_0000_0003, 0, 1, 1, 0));
    check_stats("t5", 1, 32, 1, 0);
    clear_logs();
    mac_q.push_back(mkw(64'h7000_0000_0000_0000, 1, 1, 0, 6));
    wait_rx("t5_next_count", 1, 40);
    check_rx("t5_next", 0, mkw(64'h7000_0000_0000_0000, 1, 1, 0, 6));
    check_stats("t5_next", 2, 38, 1, 0);

    // reset while word 2 of a 5-word packet is on the bus
    tick();
    sel = 1'b0;
    clear_logs();
    for (int i = 0; i < 5; i++)
      mac_q.push_back(mkw(64'h8000_0000_0000_0000 + 64'(i), i == 0, i == 4, 0, 1));
    for (int i = 0; i < 40 && tx_cyc.size() < 3; i++) tick();
    check("t6_reach_word2", tx_cyc.size(), 3);
    rst = 1'b1;
    mac_q.delete();
    @(negedge clk);
    check("t6_ren_during_rst", o_ren, 0);
    tick();
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    check("t6_ren_after_rst", o_ren, 0);
    check("t6_out_val_after_rst", o_val, 0);
    check("t6_out_data_after_rst", o_data, 0);
    check_stats("t6_rst", 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    check("t6_no_eop_emitted", rx_q.size(), 0);
    mac_q.push_back(mkw(64'h9000_0000_0000_0000, 1, 0, 0, 0));
    mac_q.push_back(mkw(64'h9000_0000_0000_0001, 0, 1, 0, 7));
    wait_rx("t6_count", 2, 40);
    check_rx("t6", 0, mkw(64'h9000_0000_0000_0000, 1, 0, 0, 0));
    check_rx("t6", 1, mkw(64'h9000_0000_0000_0001, 0, 1, 0, 7));
    check_stats("t6", 1, 15, 0, 0);

    check("no_read_past_eop", overreads, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_rx_reader.md
PKT_RX_READER -- requirements
Module: pkt_rx_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in 64-bit words (power of 2, >=4).
REQ-002 SHALL have parameter MAX_WORDS, default 1200, maximum words per packet before truncation.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports pkt_rx_avail/pkt_rx_val/pkt_rx_sop/pkt_rx_eop/pkt_rx_err  input  1 each  MAC receive status and framing.
REQ-006 SHALL have ports pkt_rx_mod  input  3  valid bytes in eop word (0 = 8), and pkt_rx_data  input  64  MAC receive data.
REQ-007 SHALL have port pkt_rx_ren  output  1  read enable to MAC; data returns with pkt_rx_val one cycle later.
REQ-008 SHALL have ports out_data  output  64, out_mod  output  3, out_val/out_sop/out_eop/out_err  output  1 each  downstream stream.
REQ-009 SHALL have port out_rdy  input  1  downstream accept; word transfers when out_val && out_rdy.
REQ-010 SHALL have ports pkt_cnt  output  32, byte_cnt  output  32, err_cnt  output  16, proto_err_cnt  output  16  statistics.

Function
REQ-011 SHALL implement FSM states IDLE, READ, DISCARD.
REQ-012 IDLE -> READ when pkt_rx_avail=1 and buffer free slots >=2; pkt_rx_ren asserts in the first READ cycle.
REQ-013 In READ, pkt_rx_ren = !(pkt_rx_val && pkt_rx_eop) && free slots >=2, counting the in-flight word as occupying a slot (combinational eop gating; no read issued past eop).
REQ-014 READ -> IDLE on pkt_rx_val && pkt_rx_eop; one idle cycle minimum between packets.
REQ-015 Each pkt_rx_val word SHALL be written to the FIFO with sop/eop/mod/err; the buffer SHALL never overflow and never drop an accepted word.
REQ-016 out_* SHALL present the FIFO head; out_val=1 iff FIFO non-empty; head pops on out_val && out_rdy; write and pop in the same cycle keep occupancy constant.
REQ-017 Latency pkt_rx_val to out_val SHALL be exactly 1 cycle when FIFO empty.
REQ-018 Word with pkt_rx_sop while already in a packet: written with out_sop=1, and the previous packet closed by setting out_err=1 on this word; proto_err_cnt +1.
REQ-019 Word with pkt_rx_val, no pkt_rx_sop, while not in a packet: dropped, proto_err_cnt +1.
REQ-020 Word number MAX_WORDS without eop: written with out_eop=1, out_err=1, out_mod=0; FSM -> DISCARD, which holds pkt_rx_ren (ignoring FIFO room), drops words until pkt_rx_eop, then -> IDLE; err_cnt +1.
REQ-021 On each eop written: pkt_cnt +1; byte_cnt += (mod==0 ? 8 : mod) + 8*(words-1); err_cnt +1 if any word in the packet had pkt_rx_err.
REQ-022 Counters SHALL wrap modulo 2^width, no saturation.

Reset
REQ-023 On rst=1 at a clock edge: state IDLE, pkt_rx_ren=0, FIFO empty, out_val=0, out_sop/out_eop/out_err=0, out_data=0, out_mod=0, all counters 0.
REQ-024 Reset mid-packet SHALL abandon the packet without emitting eop; a word arriving the cycle after reset falls under REQ-019.
REQ-025 pkt_rx_ren SHALL be 0 in the cycle rst is asserted (combinational gate on rst).

Configuration
REQ-026 Macro PKT_RX_READER_STATS_EN defined: pkt_cnt, byte_cnt, err_cnt, proto_err_cnt implemented per REQ-021/022.
REQ-027 Macro PKT_RX_READER_STATS_EN undefined: counter logic absent, all four counter outputs tied to 0; datapath behaviour identical.

Verification
REQ-028 3-word packet, out_rdy=1, mod=5 -> 3 out words 1 cycle after each val, sop on word 0, eop on word 2 with mod=5, pkt_cnt=1, byte_cnt=21.
REQ-029 10-word packet, out_rdy=0 for 20 cycles then 1 -> pkt_rx_ren drops once 2 free slots remain, no word lost, 10 words delivered in order.
REQ-030 Two packets with pkt_rx_err on word 1 of the first -> err_cnt=1, pkt_cnt=2, second packet clean.
REQ-031 MAX_WORDS=4, 7-word packet -> 4 words out, word 3 out_eop=1 out_err=1, words 4-6 discarded, err_cnt=1, FSM back to IDLE after MAC eop.
REQ-032 Orphan val without sop in IDLE, then sop inside a packet -> proto_err_cnt=2, orphan dropped, second sop word carries out_err=1.
REQ-033 rst asserted on word 2 of a 5-word packet -> next cycle pkt_rx_ren=0, out_val=0, counters 0; subsequent clean packet received correctly.
